// File: rtl/if1_fetch_buf_if.sv
// Handshake and payload bundle between the ICache response port, the IF1 fetch
// buffer and the fetch FIFO / decoder. The buffer uses the slave view.
interface if1_fetch_buf_if #(
    parameter int FETCH_WIDTH = 2,
    parameter int EXC_W       = 7,
    parameter int COOKIE_W    = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic [31:0]               in_pc;
    logic [32*FETCH_WIDTH-1:0] in_data;
    logic [31:0]               in_badv;
    logic [EXC_W-1:0]          in_exception;
    logic [COOKIE_W-1:0]       in_cookie;

    logic                      out_valid;
    logic                      out_ready;
    logic [31:0]               out_pc;
    logic [32*FETCH_WIDTH-1:0] out_inst;
    logic [FETCH_WIDTH-1:0]    out_mask;
    logic [31:0]               out_badv;
    logic [EXC_W-1:0]          out_exception;
    logic [COOKIE_W-1:0]       out_cookie;

    modport master (
        output in_valid, in_pc, in_data, in_badv, in_exception, in_cookie, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_mask, out_badv,
               out_exception, out_cookie
    );

    modport slave (
        input  in_valid, in_pc, in_data, in_badv, in_exception, in_cookie, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_mask, out_badv,
               out_exception, out_cookie
    );
endinterface

// File: rtl/if1_fetch_buf.sv
// IF1 fetch buffer: registers ICache fetch packets into a DEPTH-entry ring,
// computing the per-lane valid mask at push time, with flush and async reset.
module if1_fetch_buf #(
    parameter int FETCH_WIDTH = 2,
    parameter int DEPTH       = 2,
    parameter int EXC_W       = 7,
    parameter int COOKIE_W    = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    if1_fetch_buf_if.slave             bus,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int LANE_W  = 32 * FETCH_WIDTH;
    localparam int LOG_FW  = $clog2(FETCH_WIDTH);
    localparam int START_W = (LOG_FW > 0) ? LOG_FW : 1;
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]       r_count;
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;

    logic [31:0]            r_pcMem     [DEPTH];
    logic [LANE_W-1:0]      r_dataMem   [DEPTH];
    logic [FETCH_WIDTH-1:0] r_maskMem   [DEPTH];
    logic [31:0]            r_badvMem   [DEPTH];
    logic [EXC_W-1:0]       r_excMem    [DEPTH];
    logic [COOKIE_W-1:0]    r_cookieMem [DEPTH];

    logic                   w_inReady;
    logic                   w_outValid;
    logic                   w_push;
    logic                   w_pop;
    logic [START_W-1:0]     w_start;
    logic [FETCH_WIDTH-1:0] w_mask;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Handshake depends only on registered occupancy, never on out_ready.
    assign w_inReady  = (r_count < CNT_W'(DEPTH));
    assign w_outValid = (r_count != '0);
    assign w_push     = bus.in_valid && w_inReady && !flush;
    assign w_pop      = w_outValid && bus.out_ready && !flush;

    generate
        if (FETCH_WIDTH > 1) begin : g_start
            assign w_start = bus.in_pc[2 +: START_W];
        end else begin : g_noStart
            assign w_start = '0;
        end
    endgenerate

    // A faulting packet keeps only the lane the fetch began at.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (bus.in_exception != '0) begin
                w_mask[i] = (i == int'(w_start));
            end else begin
                w_mask[i] = (i >= int'(w_start));
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else if (flush) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= nextPtr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= nextPtr(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: every read is gated by out_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pcMem[r_wptr]     <= bus.in_pc;
            r_dataMem[r_wptr]   <= bus.in_data;
            r_maskMem[r_wptr]   <= w_mask;
            r_badvMem[r_wptr]   <= bus.in_badv;
            r_excMem[r_wptr]    <= bus.in_exception;
            r_cookieMem[r_wptr] <= bus.in_cookie;
        end
    end

    assign bus.in_ready      = w_inReady;
    assign bus.out_valid     = w_outValid;
    assign bus.out_pc        = w_outValid ? r_pcMem[r_rptr]     : '0;
    assign bus.out_inst      = w_outValid ? r_dataMem[r_rptr]   : '0;
    assign bus.out_mask      = w_outValid ? r_maskMem[r_rptr]   : '0;
    assign bus.out_badv      = w_outValid ? r_badvMem[r_rptr]   : '0;
    assign bus.out_exception = w_outValid ? r_excMem[r_rptr]    : '0;
    assign bus.out_cookie    = w_outValid ? r_cookieMem[r_rptr] : '0;
    assign count             = r_count;
endmodule

// File: tb/tb_if1_fetch_buf.sv
// Self-checking bench for if1_fetch_buf: mask table, directed corner sequences
// and a randomized phase, all compared against a queue-based packet model.
module tb_if1_fetch_buf;
    localparam int FW       = 2;
    localparam int DEPTH    = 2;
    localparam int EXC_W    = 7;
    localparam int COOKIE_W = 32;

    typedef struct {
        logic [31:0]     pc;
        logic [32*FW-1:0] data;
        logic [31:0]     badv;
        logic [EXC_W-1:0] exc;
        logic [31:0]     cookie;
    } pkt_t;

    typedef struct {
        logic [31:0]      pc;
        logic [EXC_W-1:0] exc;
        logic [31:0]      badv;
        logic [FW-1:0]    expMask;
    } vec_t;

    logic       clk;
    logic       rstn;
    logic       flush;
    logic [1:0] count;
    int         nChecks;
    int         nPass;
    pkt_t       refQ[$];
    vec_t       vecs[6];

    if1_fetch_buf_if #(.FETCH_WIDTH(FW), .EXC_W(EXC_W), .COOKIE_W(COOKIE_W)) bus ();

    if1_fetch_buf #(
        .FETCH_WIDTH(FW), .DEPTH(DEPTH), .EXC_W(EXC_W), .COOKIE_W(COOKIE_W)
    ) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .bus(bus), .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Lanes from the fetch start onward are valid; a fault keeps only the start lane.
    function automatic logic [FW-1:0] refMask(input logic [31:0] pc, input logic [EXC_W-1:0] exc);
        int start;
        start = int'(pc[31:2]) % FW;
        if (exc != '0) begin
            return FW'(1 << start);
        end
        return FW'(((1 << FW) - 1) & ~((1 << start) - 1));
    endfunction

    task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end else begin
            nPass++;
        end
    endtask

    task automatic checkOutput();
        pkt_t h;
        checkEq("count", 64'(count), 64'(refQ.size()));
        checkEq("in_ready", 64'(bus.in_ready), 64'(refQ.size() < DEPTH));
        checkEq("out_valid", 64'(bus.out_valid), 64'(refQ.size() != 0));
        if (refQ.size() != 0) begin
            h = refQ[0];
            checkEq("out_pc", 64'(bus.out_pc), 64'(h.pc));
            checkEq("out_inst", 64'(bus.out_inst), 64'(h.data));
            checkEq("out_mask", 64'(bus.out_mask), 64'(refMask(h.pc, h.exc)));
            checkEq("out_badv", 64'(bus.out_badv), 64'(h.badv));
            checkEq("out_exception", 64'(bus.out_exception), 64'(h.exc));
            checkEq("out_cookie", 64'(bus.out_cookie), 64'(h.cookie));
        end else begin
            checkEq("idle_fields", {bus.out_pc, bus.out_badv} | 64'(bus.out_inst)
                    | 64'(bus.out_mask) | 64'(bus.out_exception) | 64'(bus.out_cookie), 64'd0);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] badv,
                                 input logic [EXC_W-1:0] exc, input logic ordy, input logic fl);
        bus.in_valid     = v;
        bus.in_pc        = pc;
        bus.in_data      = {$urandom(), $urandom()};
        bus.in_badv      = badv;
        bus.in_exception = exc;
        bus.in_cookie    = $urandom();
        bus.out_ready    = ordy;
        flush            = fl;
    endtask

    // Advance one clock: update the model from the inputs seen at the edge, then check.
    task automatic tick();
        pkt_t p;
        logic doPush;
        logic doPop;
        @(posedge clk);
        if (!rstn || flush) begin
            refQ.delete();
        end else begin
            doPop  = (refQ.size() != 0) && bus.out_ready;
            doPush = bus.in_valid && (refQ.size() < DEPTH);
            if (doPop) begin
                refQ.delete(0);
            end
            if (doPush) begin
                p.pc     = bus.in_pc;
                p.data   = bus.in_data;
                p.badv   = bus.in_badv;
                p.exc    = bus.in_exception;
                p.cookie = bus.in_cookie;
                refQ.push_back(p);
            end
        end
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(1'b0, 32'h0, 32'h0, '0, ordy, 1'b0);
    endtask

    initial begin
        nChecks = 0;
        nPass   = 0;
        rstn    = 1'b0;
        idle(1'b0);

        vecs[0] = '{32'h1C000000, 7'h00, 32'h00000000, 2'b11};
        vecs[1] = '{32'h1C000004, 7'h00, 32'h00000000, 2'b10};
        vecs[2] = '{32'h1C000000, 7'h08, 32'h1C000000, 2'b01};
        vecs[3] = '{32'h1C000004, 7'h08, 32'h1C000004, 2'b10};
        vecs[4] = '{32'h1C000002, 7'h00, 32'h00000000, 2'b11};
        vecs[5] = '{32'h1C00000E, 7'h05, 32'h1C00000E, 2'b10};

        #2;
        checkOutput();
        tick();
        tick();
        rstn = 1'b1;
        checkOutput();

        // Streaming two packets back to back with the consumer always ready.
        applyStimulus(1'b1, 32'h1C000000, 32'h0, '0, 1'b1, 1'b0);
        tick();
        checkEq("stream_first_pc", 64'(bus.out_pc), 64'h1C000000);
        checkEq("stream_first_mask", 64'(bus.out_mask), 64'h3);
        applyStimulus(1'b1, 32'h1C000008, 32'h0, '0, 1'b1, 1'b0);
        tick();
        checkEq("stream_second_pc", 64'(bus.out_pc), 64'h1C000008);
        checkEq("stream_second_mask", 64'(bus.out_mask), 64'h3);
        idle(1'b1);
        tick();

        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, vecs[k].pc, vecs[k].badv, vecs[k].exc, 1'b0, 1'b0);
            tick();
            idle(1'b1);
            checkEq($sformatf("vec%0d_mask", k), 64'(bus.out_mask), 64'(vecs[k].expMask));
            checkEq($sformatf("vec%0d_pc", k), 64'(bus.out_pc), 64'(vecs[k].pc));
            checkEq($sformatf("vec%0d_exc", k), 64'(bus.out_exception), 64'(vecs[k].exc));
            checkEq($sformatf("vec%0d_badv", k), 64'(bus.out_badv), 64'(vecs[k].badv));
            tick();
        end

        // Back-pressure: third packet waits until a slot frees, then lands on the wrapped pointer.
        applyStimulus(1'b1, 32'h1C000100, 32'h0, '0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h1C000108, 32'h0, '0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h1C000110, 32'h0, '0, 1'b0, 1'b0);
        tick();
        checkEq("bp_count_full", 64'(count), 64'd2);
        checkEq("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        checkEq("bp_head_held", 64'(bus.out_pc), 64'h1C000100);
        applyStimulus(1'b1, 32'h1C000110, 32'h0, '0, 1'b1, 1'b0);
        tick();
        checkEq("bp_drain_second", 64'(bus.out_pc), 64'h1C000108);
        applyStimulus(1'b1, 32'h1C000110, 32'h0, '0, 1'b1, 1'b0);
        tick();
        checkEq("bp_third_after_wrap", 64'(bus.out_pc), 64'h1C000110);
        idle(1'b1);
        tick();

        // Steady push and pop at occupancy one.
        applyStimulus(1'b1, 32'h1C000200, 32'h0, '0, 1'b0, 1'b0);
        tick();
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, 32'h1C000200 + 32'(8 * k), 32'h0, '0, 1'b1, 1'b0);
            tick();
            checkEq($sformatf("pp%0d_count", k), 64'(count), 64'd1);
            checkEq($sformatf("pp%0d_pc", k), 64'(bus.out_pc), 64'(32'h1C000200 + 32'(8 * k)));
        end
        idle(1'b1);
        tick();

        // Flush with a full buffer and a same-cycle push.
        applyStimulus(1'b1, 32'h1C000300, 32'h0, '0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h1C000308, 32'h0, '0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h1C000310, 32'h0, '0, 1'b1, 1'b1);
        tick();
        checkEq("flush_out_valid", 64'(bus.out_valid), 64'd0);
        checkEq("flush_count", 64'(count), 64'd0);
        checkEq("flush_in_ready", 64'(bus.in_ready), 64'd1);
        idle(1'b1);
        tick();
        tick();

        // Asynchronous reset between clock edges with two packets buffered.
        applyStimulus(1'b1, 32'h1C000400, 32'h0, '0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h1C000408, 32'h0, '0, 1'b0, 1'b0);
        tick();
        idle(1'b0);
        #2;
        rstn = 1'b0;
        #1;
        checkEq("areset_out_valid", 64'(bus.out_valid), 64'd0);
        checkEq("areset_count", 64'(count), 64'd0);
        refQ.delete();
        tick();
        rstn = 1'b1;
        checkOutput();
        idle(1'b1);
        tick();

        for (int k = 0; k < 400; k++) begin
            logic [31:0] pc;
            logic [EXC_W-1:0] exc;
            pc  = $urandom();
            exc = ($urandom_range(0, 3) == 0) ? EXC_W'($urandom_range(1, 127)) : '0;
            applyStimulus(1'($urandom_range(0, 1)), pc, $urandom(), exc,
                          ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
            tick();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
